// File: rtl/syscall_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syscall_panel_pkg
// Description : Shared constants for the syscall panel. It holds the segment
//               bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} cathode bus
//               and the active-low hex-to-7-segment table for digits 0-F.
// Revision    : 1.0 - initial release
// ============================================================================
package syscall_panel_pkg;

  // Bit positions of the segments inside the seg output bus
  localparam int c_SEG_A  = 0;
  localparam int c_SEG_B  = 1;
  localparam int c_SEG_C  = 2;
  localparam int c_SEG_D  = 3;
  localparam int c_SEG_E  = 4;
  localparam int c_SEG_F  = 5;
  localparam int c_SEG_G  = 6;
  localparam int c_SEG_DP = 7;

  localparam int c_NUM_DIGITS = 8;

  // Active-low {g,f,e,d,c,b,a} patterns for 0-9, A, b, C, d, E, F
  localparam logic [6:0] c_HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : syscall_panel_pkg
`default_nettype wire

// File: rtl/syscall_panel_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Ports       : i_hex - 4-bit nibble to display
//               o_seg - {g,f,e,d,c,b,a} cathodes, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
  import syscall_panel_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = c_HEX_SEG[i_hex];

endmodule : hex7seg
`default_nettype wire

// File: rtl/syscall_panel.sv
`default_nettype none
// ============================================================================
// Module      : syscall_panel
// Description : Front panel for a CPU that halts on SYSCALL. It debounces the
//               GO push-button into a single resume pulse and multiplexes the
//               32-bit display word over eight 7-segment digits.
// Ports       : clk        - system clock, rising edge
//               CLR_n      - asynchronous active-low reset
//               display    - word shown on the digits (captured while halt=1)
//               halt       - CPU halted, waiting for GO
//               btn_go     - raw push-button, high = pressed
//               GO         - one-cycle resume pulse
//               an         - digit anodes, active-low
//               seg        - {dp,g,f,e,d,c,b,a} cathodes, active-low
//               halted_led - halt delayed one cycle
// Config      : define SYSCALL_PANEL_LZB_EN to blank leading-zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_panel
  import syscall_panel_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int DEBOUNCE_CYC = 500000
)
(
  input  logic        clk,
  input  logic        CLR_n,
  input  logic [31:0] display,
  input  logic        halt,
  input  logic        btn_go,
  output logic        GO,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        halted_led
);

  localparam int                  c_PRE_W   = $clog2(CLK_DIV);
  localparam int                  c_DB_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_CYC - 1);

  logic               r_sync0;
  logic               r_sync1;
  logic [1:0]         r_prime;
  logic               r_stable;
  logic               r_stable_d;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic               r_arm;
  logic               r_go;
  logic [31:0]        r_shadow;
  logic [c_PRE_W-1:0] r_pre;
  logic [2:0]         r_idx;
  logic [7:0]         r_an;
  logic [7:0]         r_seg;
  logic               r_halted;

  logic               w_rise;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg7;
  logic               w_dp_on;
  logic               w_digit_on;
  logic [7:0]         w_an;
  logic [7:0]         w_seg;

  assign w_rise  = r_stable & ~r_stable_d;
  assign w_nib   = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_dp_on = (r_idx == 3'd0) & halt;

  hex7seg u_hex7seg (
    .i_hex (w_nib),
    .o_seg (w_seg7)
  );

`ifdef SYSCALL_PANEL_LZB_EN
  // Highest digit holding a non-zero nibble; digit 0 stays lit for a zero word
  logic [2:0] w_msd;
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < c_NUM_DIGITS; i++) begin
      if (r_shadow[4*i +: 4] != 4'h0) w_msd = 3'(i);
    end
  end
  assign w_digit_on = (r_idx <= w_msd);
`else
  assign w_digit_on = 1'b1;
`endif

  always_comb begin
    w_an  = 8'hFF;
    w_seg = 8'hFF;
    if (w_digit_on) begin
      w_an[r_idx]              = 1'b0;
      w_seg[c_SEG_G:c_SEG_A]   = w_seg7;
      w_seg[c_SEG_DP]          = ~w_dp_on;
    end
  end

  // Button path: synchronizer, debounce, arm and GO generation
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_sync0    <= 1'b0;
      r_sync1    <= 1'b0;
      r_prime    <= 2'b00;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_db_cnt   <= '0;
      r_arm      <= 1'b0;
      r_go       <= 1'b0;
    end else begin
      r_sync0    <= btn_go;
      r_sync1    <= r_sync0;
      // r_sync1 only reflects the real button two cycles after reset release
      r_prime    <= {r_prime[0], 1'b1};
      r_stable_d <= r_stable;

      if (r_sync1 != r_stable) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_stable <= ~r_stable;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end

      // Arming requires an observed release, so a button held through reset
      // cannot fire. Every debounced press consumes the arm, used or not.
      r_go <= 1'b0;
      if (w_rise) begin
        r_go  <= r_arm & halt;
        r_arm <= 1'b0;
      end else if (!r_stable && !r_sync1 && r_prime[1]) begin
        r_arm <= 1'b1;
      end
    end
  end

  // Display path: shadow capture, scan prescaler and registered digit drive
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_shadow <= '0;
      r_pre    <= '0;
      r_idx    <= 3'd0;
      r_an     <= 8'hFF;
      r_seg    <= 8'hFF;
      r_halted <= 1'b0;
    end else begin
      if (halt) r_shadow <= display;
      if (r_pre == c_PRE_LAST) begin
        r_pre <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_an     <= w_an;
      r_seg    <= w_seg;
      r_halted <= halt;
    end
  end

  assign GO         = r_go;
  assign an         = r_an;
  assign seg        = r_seg;
  assign halted_led = r_halted;

endmodule : syscall_panel
`default_nettype wire

// File: doc/syscall_panel.md
SYSCALL_PANEL -- requirements
Module: syscall_panel

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clk cycles per digit-scan slot (min 2).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500000, consecutive stable cycles to accept a button level change (min 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 CLR_n  input  1  reset, asynchronous assert, active-low.
REQ-005 display  input  32  word driven by the CPU syscall unit.
REQ-006 halt  input  1  CPU halted on SYSCALL, waiting for GO.
REQ-007 btn_go  input  1  raw asynchronous push-button, high = pressed.
REQ-008 GO  output  1  one-cycle resume pulse to the CPU.
REQ-009 an  output  8  digit anodes, active-low, one-hot-low when lit.
REQ-010 seg  output  8  {dp,g,f,e,d,c,b,a} cathodes, active-low.
REQ-011 halted_led  output  1  registered copy of halt.

Function
REQ-012 btn_go SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Debounce: stable level SHALL toggle only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears the counter.
REQ-014 arm flag SHALL set while stable=0 and clear when a GO is issued.
REQ-015 GO SHALL be 1 for exactly the one cycle after stable rises 0->1 with arm=1 and halt=1; otherwise GO=0.
REQ-016 A stable rising edge while halt=0 SHALL be discarded and SHALL clear arm (no queued GO).
REQ-017 Holding the button SHALL yield at most one GO; a new GO requires release (stable=0) and re-press.
REQ-018 Shadow register SHALL load display on every cycle where halt=1, and hold while halt=0.
REQ-019 Prescaler SHALL count 0..CLK_DIV-1 and wrap; digit index (3 bits) SHALL increment on wrap, 7->0.
REQ-020 Digit i SHALL show shadow[4i+3:4i] as hex 0-F; dp SHALL be lit only on digit 0 while halt=1.
REQ-021 an and seg SHALL be registered, updating the cycle after the index changes (1-cycle latency).
REQ-022 halted_led SHALL equal halt delayed one cycle.

Reset
REQ-023 While CLR_n=0: GO=0, an=8'hFF, seg=8'hFF, halted_led=0, shadow=0, index=0, prescaler=0, sync flops=0, stable=0, debounce counter=0, arm=0.
REQ-024 Reset mid-debounce or mid-press SHALL discard progress; a button held through reset release SHALL NOT produce GO until released and re-pressed.

Configuration
REQ-025 Macro SYSCALL_PANEL_LZB_EN defined: digits above the most significant non-zero nibble SHALL be blanked (an bit high); digit 0 always lit.
REQ-026 Macro undefined: all 8 digits SHALL be lit in scan, leading zeros shown.

Structure
REQ-027 Shared package SHALL hold the 16-entry hex-to-segment constant table and the segment bit-order constants.
REQ-028 Hex decode SHALL be sub-module hex7seg (4-bit in, 7-bit active-low out); debounce and scan stay in syscall_panel.

Verification (CLK_DIV=4, DEBOUNCE_CYC=8)
REQ-029 halt=1, display=32'h1234ABCD, no button -> an cycles FE,FD,...,7F each 4 cycles; seg on an=FE is "D" with dp lit; GO stays 0.
REQ-030 halt=1, btn_go 0->1 held 40 cycles -> exactly one GO pulse, 11 cycles after btn_go rises (2 sync + 8 debounce + 1); none during hold.
REQ-031 btn_go glitch high for 5 cycles -> stable unchanged, GO=0.
REQ-032 halt=0, full press/release -> GO=0; then halt=1 with no new press -> GO=0.
REQ-033 btn_go held high across CLR_n pulse -> GO=0 until release (>=10 cycles low) and re-press, then one GO.
REQ-034 display=32'h0000_00A5, halt=1 -> with SYSCALL_PANEL_LZB_EN only an=FE,FD ever low; without it all 8 digits scan, upper six showing "0".
